// File: rtl/mvm_pkg.sv
// Shared MVM constants and the result-drain FSM state type.
package mvm_pkg;

    localparam int MVM_K   = 32;
    localparam int MVM_B   = 8;
    localparam int MVM_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } drain_state_t;

endpackage

// File: rtl/mvm_result_fifo.sv
// K-entry result buffer: unconditional write port, first-word-fall-through read.
module mvm_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_rd;

    assign o_rd_valid = (r_count != '0);
    assign w_rd       = i_rd_en & o_rd_valid;
    // Gate the head so out_data reads zero while empty, including straight out of reset.
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_wr_en, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_result_drain.sv
// Captures K MVM results after a done pulse and streams them out over a valid/ready port.
//   state   | meaning
//   IDLE    | waiting for done
//   WAIT    | counting down the MVM readout latency
//   CAPTURE | writing y_in into the buffer, K consecutive cycles
//   DRAIN   | capture finished, waiting for the last element to be taken
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter int K   = MVM_K,
    parameter int B   = MVM_B,
    parameter int LAT = MVM_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           done,
    input  logic [2*B-1:0] y_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*B-1:0] out_data,
    output logic           out_last,
    output logic           busy,
    output logic           overrun,
    input  logic           clear_err
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(K - 1);
    localparam logic [2:0]    WAIT_LOAD = 3'(LAT - 1);

    drain_state_t  r_state;
    logic [2:0]    r_wait;
    logic [CW-1:0] r_cap_idx;
    logic [CW-1:0] r_rd_idx;
    logic          r_overrun;
    logic          w_wr;
    logic          w_hs;
    logic          w_hs_last;

    assign w_wr      = (r_state == ST_CAPTURE);
    assign w_hs      = out_valid & out_ready;
    assign w_hs_last = w_hs & out_last;

    assign busy     = (r_state != ST_IDLE);
    assign overrun  = r_overrun;
    assign out_last = out_valid & (r_rd_idx == LAST_IDX);

    mvm_result_fifo #(
        .WIDTH(2*B),
        .DEPTH(K)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr),
        .i_wr_data (y_in),
        .i_rd_en   (out_ready),
        .o_rd_valid(out_valid),
        .o_rd_data (out_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_cap_idx <= '0;
            r_rd_idx  <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (done) begin
                        r_cap_idx <= '0;
                        if (LAT == 1) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_wait  <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving on the decrement to zero puts the first write at done edge + LAT.
                    r_wait <= r_wait - 1'b1;
                    if (r_wait == 3'd1) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (r_cap_idx == LAST_IDX) begin
                        r_cap_idx <= '0;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_cap_idx <= r_cap_idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_hs_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_hs) begin
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
            end

            if (done && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvm_result_drain.sv
// Bench for mvm_result_drain: LAT=2 and LAT=1 instances against a timing-rule queue model.
module tb_mvm_result_drain;

    localparam int K = 4;
    localparam int B = 8;
    localparam int W = 2 * B;

    logic         clk = 1'b0;
    logic         reset;
    logic         done;
    logic [W-1:0] y_in;
    logic         out_ready;
    logic         clear_err;

    logic         w_valid [2];
    logic [W-1:0] w_data  [2];
    logic         w_last  [2];
    logic         w_busy  [2];
    logic         w_ovr   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mvm_result_drain #(.K(K), .B(B), .LAT(2)) u_dut0 (
        .clk(clk), .reset(reset), .done(done), .y_in(y_in),
        .out_valid(w_valid[0]), .out_ready(out_ready), .out_data(w_data[0]),
        .out_last(w_last[0]), .busy(w_busy[0]), .overrun(w_ovr[0]),
        .clear_err(clear_err)
    );

    mvm_result_drain #(.K(K), .B(B), .LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .done(done), .y_in(y_in),
        .out_valid(w_valid[1]), .out_ready(out_ready), .out_data(w_data[1]),
        .out_last(w_last[1]), .busy(w_busy[1]), .overrun(w_ovr[1]),
        .clear_err(clear_err)
    );

    // Model: a job is "edges since done"; captures land at offsets LAT..LAT+K-1,
    // the job ends when K elements have been handed over.
    int           m_lat    [2];
    logic [W-1:0] m_buf    [2][64];
    int           m_head   [2];
    int           m_tail   [2];
    int           m_c      [2];
    int           m_popped [2];
    bit           m_active [2];
    bit           m_ovr    [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_head[d] = 0; m_tail[d] = 0; m_c[d] = 0; m_popped[d] = 0;
            m_active[d] = 1'b0; m_ovr[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit old_active;
            bit hs;
            old_active = m_active[d];
            hs = ((m_tail[d] - m_head[d]) > 0) && out_ready;
            if (hs) begin
                m_head[d]++;
                m_popped[d]++;
                if (m_popped[d] == K) begin
                    m_active[d] = 1'b0;
                    m_popped[d] = 0;
                end
            end
            if (old_active) begin
                m_c[d]++;
                if (m_c[d] >= m_lat[d] && m_c[d] < m_lat[d] + K) begin
                    m_buf[d][m_tail[d] % 64] = y_in;
                    m_tail[d]++;
                end
            end
            if (done) begin
                if (old_active) m_ovr[d] = 1'b1;
                else begin
                    m_active[d] = 1'b1;
                    m_c[d] = 0;
                    m_popped[d] = 0;
                end
            end else if (clear_err) begin
                m_ovr[d] = 1'b0;
            end
        end
    endtask

    task automatic model_check(input string tag);
        for (int d = 0; d < 2; d++) begin
            bit           ev;
            logic [W-1:0] ed;
            ev = (m_tail[d] - m_head[d]) > 0;
            ed = ev ? m_buf[d][m_head[d] % 64] : '0;
            chk($sformatf("%s_valid%0d", tag, d), 32'(w_valid[d]), 32'(ev));
            chk($sformatf("%s_data%0d",  tag, d), 32'(w_data[d]),  32'(ed));
            chk($sformatf("%s_last%0d",  tag, d), 32'(w_last[d]),  32'(ev && (m_popped[d] == K - 1)));
            chk($sformatf("%s_busy%0d",  tag, d), 32'(w_busy[d]),  32'(m_active[d]));
            chk($sformatf("%s_ovr%0d",   tag, d), 32'(w_ovr[d]),   32'(m_ovr[d]));
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic drive(input bit d, input bit rdy, input bit clr);
        done = d; out_ready = rdy; clear_err = clr; y_in = W'($urandom);
    endtask

    task automatic idle_cycles(input int n, input bit rdy, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, rdy, 1'b0);
            cycle(tag);
        end
    endtask

    typedef struct {
        bit           done;
        logic [W-1:0] y;
        bit           ready;
        bit           v;
        logic [W-1:0] d;
        bit           l;
        bit           bz;
    } vec_t;

    vec_t tbl [18];

    initial begin
        m_lat[0] = 2;
        m_lat[1] = 1;
        //            done  y         rdy  valid data      last busy
        tbl[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'h0033, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0005, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'hFFFD, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'h0064, 1'b1, 1'b1, 16'h0064, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 16'h0007, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0008, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0009, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 16'h000A, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0009, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

        reset = 1'b1; done = 1'b0; out_ready = 1'b0; clear_err = 1'b0; y_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(w_valid[d]), 32'd0);
            chk($sformatf("rst_data%0d",  d), 32'(w_data[d]),  32'd0);
            chk($sformatf("rst_last%0d",  d), 32'(w_last[d]),  32'd0);
            chk($sformatf("rst_busy%0d",  d), 32'(w_busy[d]),  32'd0);
            chk($sformatf("rst_ovr%0d",   d), 32'(w_ovr[d]),   32'd0);
        end
        reset = 1'b0;
        idle_cycles(2, 1'b1, "pre");

        // Directed job, backpressured back-to-back job.
        for (int i = 0; i < 18; i++) begin
            done = tbl[i].done; y_in = tbl[i].y; out_ready = tbl[i].ready; clear_err = 1'b0;
            cycle("tbl");
            chk($sformatf("vec%0d_valid", i), 32'(w_valid[0]), 32'(tbl[i].v));
            chk($sformatf("vec%0d_data",  i), 32'(w_data[0]),  32'(tbl[i].d));
            chk($sformatf("vec%0d_last",  i), 32'(w_last[0]),  32'(tbl[i].l));
            chk($sformatf("vec%0d_busy",  i), 32'(w_busy[0]),  32'(tbl[i].bz));
            chk($sformatf("vec%0d_ovr",   i), 32'(w_ovr[0]),   32'd0);
            if (i == 1) begin
                chk("lat1_first_valid", 32'(w_valid[1]), 32'd1);
                chk("lat1_first_data",  32'(w_data[1]),  32'h0033);
            end
        end
        idle_cycles(3, 1'b1, "gap");

        // Long backpressure: all K words held, then released in order.
        drive(1'b1, 1'b0, 1'b0); cycle("bp");
        idle_cycles(20, 1'b0, "bp");
        idle_cycles(8, 1'b1, "bp");

        // Done during capture sets overrun; clear_err clears it.
        drive(1'b1, 1'b1, 1'b0); cycle("ovr");
        idle_cycles(2, 1'b1, "ovr");
        drive(1'b1, 1'b1, 1'b0); cycle("ovr");
        chk("ovr_set", 32'(w_ovr[0]), 32'd1);
        idle_cycles(8, 1'b1, "ovr");
        drive(1'b0, 1'b1, 1'b1); cycle("clr");
        chk("ovr_clr", 32'(w_ovr[0]), 32'd0);

        // Set wins over clear in the same cycle.
        drive(1'b1, 1'b1, 1'b0); cycle("sw");
        drive(1'b1, 1'b1, 1'b1); cycle("sw");
        chk("ovr_set_wins", 32'(w_ovr[0]), 32'd1);
        idle_cycles(8, 1'b1, "sw");
        drive(1'b0, 1'b1, 1'b1); cycle("sw");

        // Done on the cycle of the final handshake (LAT=2: done edge + 6) is ignored.
        drive(1'b1, 1'b1, 1'b0); cycle("edge");
        idle_cycles(5, 1'b1, "edge");
        drive(1'b1, 1'b1, 1'b0); cycle("edge");
        chk("late_done_ovr",  32'(w_ovr[0]),  32'd1);
        chk("late_done_busy", 32'(w_busy[0]), 32'd0);
        idle_cycles(8, 1'b1, "edge");
        drive(1'b0, 1'b1, 1'b1); cycle("edge");

        // Reset mid-capture: outputs drop at once, next job is clean.
        drive(1'b1, 1'b0, 1'b0); cycle("mr");
        idle_cycles(3, 1'b0, "mr");
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mr_valid%0d", d), 32'(w_valid[d]), 32'd0);
            chk($sformatf("mr_data%0d",  d), 32'(w_data[d]),  32'd0);
            chk($sformatf("mr_busy%0d",  d), 32'(w_busy[d]),  32'd0);
        end
        drive(1'b0, 1'b0, 1'b0); cycle("mr");
        reset = 1'b0;
        idle_cycles(2, 1'b1, "mr");
        drive(1'b1, 1'b1, 1'b0); cycle("mr");
        idle_cycles(10, 1'b1, "mr");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mvm_result_drain.md
MVM_RESULT_DRAIN -- requirements
Module: mvm_result_drain

Interface
REQ-001 Parameter K, default 32: vector length; number of results captured per job.
REQ-002 Parameter B, default 8: operand width; result width is 2*B.
REQ-003 Parameter LAT, default 2: cycles from the done sample to the first valid result on y_in; legal range 1..8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 done  input  1  one-cycle pulse from the MVM marking that result readout starts.
REQ-007 y_in  input  2*B  signed result word from the MVM data_out, one element per cycle.
REQ-008 out_valid  output  1  out_data holds a buffered result.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  2*B  signed result word, oldest first.
REQ-011 out_last  output  1  high with the K-th element of a job.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 overrun  output  1  sticky; a done pulse arrived while busy.
REQ-014 clear_err  input  1  synchronous clear of overrun.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, CAPTURE and DRAIN.
REQ-016 IDLE: done=1 sampled -> WAIT; load the wait counter with LAT-1.
REQ-017 Special case for LAT=1: IDLE with done=1 SHALL go directly to CAPTURE.
REQ-018 WAIT: the counter decrements each cycle; when it reaches 0, go to CAPTURE.
REQ-019 Combined effect of REQ-016 to REQ-018: for done sampled at edge T, the first capture happens at edge T+LAT.
REQ-020 CAPTURE: write y_in into the buffer on each of K consecutive edges (T+LAT .. T+LAT+K-1), unconditionally, with no backpressure to the MVM.
REQ-021 CAPTURE -> DRAIN after the K-th write; if the buffer is already empty at that point, go directly to IDLE.
REQ-022 DRAIN -> IDLE on the handshake (out_valid & out_ready) of the element carrying out_last.
REQ-023 Draining SHALL overlap capture: out_valid=1 whenever the buffer occupancy is greater than 0, in any state.
REQ-024 A transfer happens on out_valid & out_ready; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 out_data SHALL be driven from the buffer head with zero added latency: a word captured at edge E is presentable in the cycle after E.
REQ-026 out_last=1 iff the element index within the job equals K-1.
REQ-027 The buffer depth SHALL be K, so a full job never overflows regardless of out_ready.
REQ-028 Simultaneous write and read in the same cycle SHALL leave the occupancy unchanged.
REQ-029 Pointers SHALL wrap modulo K; for K not a power of 2, wrap explicitly at K-1 to 0.
REQ-030 done=1 while busy: ignore the pulse (no capture, no state change) and set overrun.
REQ-031 clear_err=1 in the same cycle as an overrun event: set wins.
REQ-032 Data SHALL pass through unmodified; no sign extension or saturation, width 2*B in and out.
REQ-033 done in the same cycle that DRAIN -> IDLE occurs counts as while busy: the pulse is ignored and overrun is set.

Reset
REQ-034 reset=1 SHALL asynchronously force: state=IDLE, all counters and pointers=0, occupancy=0, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0.
REQ-035 Buffer contents need not be reset.
REQ-036 Reset mid-job SHALL discard all captured data; the first done after reset deasserts starts a fresh job.

Structure
REQ-037 Package mvm_pkg SHALL hold the FSM state enum (drain_state_t) and the default K/B/LAT constants shared with the MVM top.
REQ-038 The K-entry buffer with its pointers and occupancy SHALL be one sub-module, mvm_result_fifo (parameters WIDTH and DEPTH, write-always interface, first-word-fall-through read).
REQ-039 The FSM and counters SHALL be in mvm_result_drain.

Verification (K=4, B=8, LAT=2)
REQ-040 done at edge 10 with y_in = 5, -3, 100, -32768 at edges 12..15 and out_ready=1 -> out_data 5, -3, 100, -32768 on consecutive cycles, out_last only on -32768, busy falls after the last handshake.
REQ-041 Same job with out_ready=0 until edge 30 -> all 4 words held; out_valid is continuously 1 from the cycle after edge 12; words are emitted in order after edge 30 with no loss.
REQ-042 Second done at edge 13 during CAPTURE -> overrun=1, capture unaffected; clear_err at edge 40 -> overrun=0.
REQ-043 reset pulse at edge 13 during CAPTURE -> outputs zero immediately; next done at edge 20 captures edges 22..25 correctly.
REQ-044 LAT=1 instance, done at edge 10 -> first capture at edge 11.
REQ-045 Back-to-back jobs: second done one cycle after the last handshake -> accepted, overrun stays 0.
